pll_lock_sequencer: RTL

- Controls the reset of the board PLL and monitors its lock output.
- On power-up or on request, it pulses the PLL reset and waits for lock with a timeout and a bounded number of retries.
- It qualifies lock as stable before asserting clk_ready, which downstream logic uses as its reset release.
- It runs on the PLL reference clock, so it stays alive while the PLL output clock is absent.

---
 rtl/pll_lock_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on refclk: pulses the PLL reset, waits for lock with timeout and retries, qualifies stability.
// Define PLL_LOCK_LOSS_CNT_EN to implement the saturating lock-loss counter; otherwise lock_loss_cnt reads 0.
module pll_lock_sequencer #(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       clk_ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    localparam int MAX_AB  = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int RW      = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

    logic [1:0]    r_sync;
    logic          w_lock_s;
    logic [2:0]    r_state;
    logic [2:0]    w_state_next;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_next;
    logic [TW-1:0] w_timer_inc;
    logic [RW-1:0] r_retry;
    logic [RW-1:0] w_retry_next;
    logic [RW-1:0] w_retry_inc;
    logic          r_pll_rst;
    logic          r_clk_ready;
    logic          r_fault;

    // pll_locked is asynchronous to refclk; only the second flop is used by the FSM.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], pll_locked};
        end
    end

    assign w_lock_s    = r_sync[1];
    assign w_timer_inc = r_timer + 1'b1;
    assign w_retry_inc = r_retry + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_retry_next = r_retry;
        if (relock_req) begin
            w_state_next = S_RESET_PLL;
            w_timer_next = '0;
            w_retry_next = '0;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_timer == RST_LAST) begin
                        w_state_next = S_WAIT_LOCK;
                        w_timer_next = '0;
                    end else begin
                        w_timer_next = w_timer_inc;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_state_next = S_STABLE;
                        w_timer_next = '0;
                    end else if (r_timer == TIMEOUT_LAST) begin
                        w_timer_next = '0;
                        w_retry_next = w_retry_inc;
                        w_state_next = (w_retry_inc == RETRY_LIMIT) ? S_FAULT : S_RESET_PLL;
                    end else begin
                        w_timer_next = w_timer_inc;
                    end
                end
                S_STABLE: begin
                    // A dropout restarts both qualification and the lock timeout, keeping the retry count.
                    if (!w_lock_s) begin
                        w_state_next = S_WAIT_LOCK;
                        w_timer_next = '0;
                    end else if (r_timer == STABLE_LAST) begin
                        w_state_next = S_RUN;
                        w_timer_next = '0;
                        w_retry_next = '0;
                    end else begin
                        w_timer_next = w_timer_inc;
                    end
                end
                S_RUN: begin
                    if (!w_lock_s) begin
                        w_state_next = S_RESET_PLL;
                        w_timer_next = '0;
                    end
                end
                S_FAULT: begin
                    w_state_next = S_FAULT;
                end
                default: begin
                    w_state_next = S_RESET_PLL;
                    w_timer_next = '0;
                    w_retry_next = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RESET_PLL;
            r_timer     <= '0;
            r_retry     <= '0;
            r_pll_rst   <= 1'b1;
            r_clk_ready <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_retry     <= w_retry_next;
            r_pll_rst   <= (w_state_next == S_RESET_PLL) || (w_state_next == S_FAULT);
            r_clk_ready <= (w_state_next == S_RUN);
            r_fault     <= (w_state_next == S_FAULT);
        end
    end

    assign pll_rst   = r_pll_rst;
    assign clk_ready = r_clk_ready;
    assign fault     = r_fault;
    assign state     = r_state;

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic       w_lock_lost;
    logic [7:0] r_loss_cnt;

    // A relock request out of RUN is deliberate, not a lock loss.
    assign w_lock_lost = (r_state == S_RUN) && !relock_req && !w_lock_s;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_loss_cnt <= 8'd0;
        end else if (w_lock_lost && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign lock_loss_cnt = r_loss_cnt;
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule
